poisson_array_scheduler: RTL and testbench

Array-side controller for the per-neuron Poisson update module. Holds the packed state of NEURON_NUM neurons (activity + refractory) in an internal RAM. Once per dT tick it sweeps the array: it drives poisson_en/poisson_in one neuron per cycle, writes the returned poisson_out back to the same address, and pushes the addresses of spiking neurons into an output spike FIFO. It sits between the host configuration path and the downstream spike router.

---
 rtl/poisson_array_scheduler_pkg.sv | 11 +
 rtl/poisson_array_scheduler_if.sv | 26 ++
 rtl/poisson_array_scheduler_fifo.sv | 34 +++
 rtl/poisson_array_scheduler.sv | 115 +++++++++++
 tb/tb_poisson_array_scheduler.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/poisson_array_scheduler_pkg.sv
// poisson_pkg: shared widths, packed neuron state and scheduler FSM states
package poisson_pkg;
   localparam int ACTIVITY_WIDTH   = 9;
   localparam int REFRACTORY_WIDTH = 4;
   localparam int NEUR_WIDTH       = ACTIVITY_WIDTH + REFRACTORY_WIDTH;
   typedef struct packed {
      logic [ACTIVITY_WIDTH-1:0]   activity;
      logic [REFRACTORY_WIDTH-1:0] refractory;
   } neuron_state_t;
   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} sched_state_t;
endpackage

// File: rtl/poisson_array_scheduler_if.sv
// poisson_array_scheduler_if: host write, Poisson update and spike output channels
interface poisson_array_scheduler_if
   import poisson_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
);
   logic                      wr_valid;
   logic                      wr_ready;
   logic [ADDR_WIDTH-1:0]     wr_addr;
   logic [ACTIVITY_WIDTH-1:0] wr_activity;
   logic                      poisson_en;
   logic [NEUR_WIDTH-1:0]     poisson_in;
   logic [NEUR_WIDTH-1:0]     poisson_out;
   logic                      spike;
   logic                      spike_valid;
   logic [ADDR_WIDTH-1:0]     spike_addr;
   logic                      spike_ready;
   modport slave (
      input  wr_valid, wr_addr, wr_activity, poisson_out, spike, spike_ready,
      output wr_ready, poisson_en, poisson_in, spike_valid, spike_addr
   );
   modport master (
      output wr_valid, wr_addr, wr_activity, poisson_out, spike, spike_ready,
      input  wr_ready, poisson_en, poisson_in, spike_valid, spike_addr
   );
endinterface

// File: rtl/poisson_array_scheduler_fifo.sv
// spike_fifo: first-word-fall-through FIFO; a pop frees room for a same-cycle push when full
module spike_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_data
);
   localparam int PW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW:0]      r_wptr, r_rptr;
   logic             w_do_pop, w_do_push;
   assign o_empty   = r_wptr == r_rptr;
   assign o_full    = r_wptr == {~r_rptr[PW], r_rptr[PW-1:0]};
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_data    = r_mem[r_rptr[PW-1:0]];
   always_ff @(posedge clk)
      if (w_do_push) r_mem[r_wptr[PW-1:0]] <= i_data;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + (PW+1)'(1);
         if (w_do_pop)  r_rptr <= r_rptr + (PW+1)'(1);
      end
endmodule

// File: rtl/poisson_array_scheduler.sv
// poisson_array_scheduler: per-tick sweep of the neuron state RAM through the Poisson update module
module poisson_array_scheduler
   import poisson_pkg::*;
#(
   parameter int NEURON_NUM  = 256,
   parameter int TICK_PERIOD = 100000,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i_enable,
   poisson_array_scheduler_if.slave bus,
   output logic                     o_busy,
   output logic                     o_overflow,
   output logic                     o_tick_miss,
   output logic [15:0]              o_drop_cnt
);
   localparam int ADDR_WIDTH = $clog2(NEURON_NUM);
   localparam int TCW        = $clog2(TICK_PERIOD);
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NEURON_NUM - 1);
   sched_state_t          r_state, w_next;
   logic [TCW-1:0]        r_tick_cnt;
   logic                  w_tick;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
   logic                  r_s1_vld, r_s2_vld;
   logic [ADDR_WIDTH-1:0] r_s1_addr, r_s2_addr;
   logic [NEUR_WIDTH-1:0] r_ram [NEURON_NUM];
   logic [NEUR_WIDTH-1:0] r_rd_data;
   logic                  w_rd_en, w_host_we, w_we;
   logic [ADDR_WIDTH-1:0] w_wr_addr;
   logic [NEUR_WIDTH-1:0] w_wr_data;
   neuron_state_t         w_host_state;
   logic                  w_push, w_pop, w_full, w_empty, w_drop;
   logic                  r_overflow, r_tick_miss;
   logic [15:0]           r_drop_cnt;
   assign w_tick = i_enable && r_tick_cnt == TCW'(TICK_PERIOD - 1);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) r_tick_cnt <= '0;
      else          r_tick_cnt <= (!i_enable || w_tick) ? '0 : r_tick_cnt + TCW'(1);
   // r_addr doubles as the DRAIN cycle counter: it is 0 on DRAIN entry
   always_comb begin
      w_next      = r_state;
      w_addr_next = '0;
      case (r_state)
         IDLE:  w_next = w_tick ? SWEEP : IDLE;
         SWEEP: begin
            w_addr_next = r_addr + ADDR_WIDTH'(1);
            w_next      = (r_addr == LAST) ? DRAIN : SWEEP;
         end
         DRAIN: begin
            w_addr_next = r_addr[0] ? '0 : ADDR_WIDTH'(1);
            w_next      = r_addr[0] ? IDLE : DRAIN;
         end
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_state   <= IDLE;
         r_addr    <= '0;
         r_s1_vld  <= 1'b0;
         r_s2_vld  <= 1'b0;
         r_s1_addr <= '0;
         r_s2_addr <= '0;
      end else begin
         r_state   <= w_next;
         r_addr    <= w_addr_next;
         r_s1_vld  <= w_rd_en;
         r_s2_vld  <= r_s1_vld;
         r_s1_addr <= r_addr;
         r_s2_addr <= r_s1_addr;
      end
   assign w_rd_en      = r_state == SWEEP;
   assign bus.wr_ready = r_state == IDLE && !w_tick;
   assign w_host_we    = bus.wr_ready && bus.wr_valid;
   assign w_host_state = '{activity: bus.wr_activity, refractory: '0};
   // host writes only happen in IDLE, after the last writeback has retired
   assign w_we      = r_s2_vld | w_host_we;
   assign w_wr_addr = r_s2_vld ? r_s2_addr : bus.wr_addr;
   assign w_wr_data = r_s2_vld ? bus.poisson_out : w_host_state;
   always_ff @(posedge clk) begin
      if (w_we)    r_ram[w_wr_addr] <= w_wr_data;
      if (w_rd_en) r_rd_data <= r_ram[r_addr];
   end
   assign bus.poisson_en = r_s1_vld;
   assign bus.poisson_in = r_s1_vld ? r_rd_data : '0;
   assign o_busy         = r_state != IDLE;
   assign w_push = r_s2_vld & bus.spike;
   assign w_pop  = bus.spike_ready & ~w_empty;
   assign w_drop = w_push & w_full & ~w_pop;
   spike_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_data  (r_s2_addr),
      .i_pop   (bus.spike_ready),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_data  (bus.spike_addr)
   );
   assign bus.spike_valid = ~w_empty;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_overflow  <= 1'b0;
         r_tick_miss <= 1'b0;
         r_drop_cnt  <= '0;
      end else begin
         r_overflow  <= r_overflow | w_drop;
         r_tick_miss <= r_tick_miss | (w_tick && r_state != IDLE);
         if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   assign o_overflow  = r_overflow;
   assign o_tick_miss = r_tick_miss;
   assign o_drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_poisson_array_scheduler.sv
// tb_poisson_array_scheduler: scoreboard bench with a +1 Poisson stub and scripted spikes
module tb_poisson_array_scheduler;
   import poisson_pkg::*;
   logic        clk = 1'b0, reset_n = 1'b0, rst2_n = 1'b0, en1 = 1'b0;
   logic        busy1, ovf1, tm1, busy2, ovf2, tm2;
   logic [15:0] dc1, dc2;
   logic [7:0]  mask = 8'h00;
   logic [2:0]  idx1;
   int          checks = 0, failures = 0, sv_cycles = 0;
   int          en2 = 0, blen2 = 0, sw2 = 0;
   int          exp_in[$], exp_sp[$];
   poisson_array_scheduler_if #(.ADDR_WIDTH(3)) b1 ();
   poisson_array_scheduler_if #(.ADDR_WIDTH(3)) b2 ();
   poisson_array_scheduler #(.NEURON_NUM(8), .TICK_PERIOD(32), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .i_enable(en1), .bus(b1),
      .o_busy(busy1), .o_overflow(ovf1), .o_tick_miss(tm1), .o_drop_cnt(dc1)
   );
   poisson_array_scheduler #(.NEURON_NUM(8), .TICK_PERIOD(4), .FIFO_DEPTH(4)) dut2 (
      .clk(clk), .reset_n(rst2_n), .i_enable(1'b1), .bus(b2),
      .o_busy(busy2), .o_overflow(ovf2), .o_tick_miss(tm2), .o_drop_cnt(dc2)
   );
   always #5 clk = ~clk;
   task automatic chk(string n, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", n, act, exp);
      end
   endtask
   task automatic miss(string n);
      checks++;
      failures++;
      $display("FAIL %s: expected event did not occur as required", n);
   endtask
   function automatic int st(int a, int r);
      neuron_state_t s;
      s.activity   = ACTIVITY_WIDTH'(a);
      s.refractory = REFRACTORY_WIDTH'(r);
      return int'(s);
   endfunction
   // Poisson stubs: registered +1 on the packed state, spike from the script mask
   always @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         idx1           <= 3'd0;
         b1.poisson_out <= '0;
         b1.spike       <= 1'b0;
      end else begin
         b1.poisson_out <= b1.poisson_in + 13'd1;
         b1.spike       <= b1.poisson_en & mask[idx1];
         if (b1.poisson_en) idx1 <= idx1 + 3'd1;
      end
   always @(posedge clk) begin
      b2.poisson_out <= b2.poisson_in + 13'd1;
      b2.spike       <= 1'b0;
   end
   always @(negedge clk)
      if (reset_n) begin
         if (b1.poisson_en) begin
            if (exp_in.size() == 0) miss("poisson_en_expected");
            else chk("poisson_in", int'(b1.poisson_in), exp_in.pop_front());
         end
         if (b1.spike_valid) begin
            sv_cycles++;
            if (b1.spike_ready) begin
               if (exp_sp.size() == 0) miss("spike_expected");
               else chk("spike_addr", int'(b1.spike_addr), exp_sp.pop_front());
            end
         end
      end
   always @(negedge clk)
      if (rst2_n) begin
         if (b2.poisson_en) en2++;
         if (busy2) blen2++;
         else if (blen2 != 0) begin
            if (sw2 < 3) begin
               chk("d2_en_per_sweep", en2, 8);
               chk("d2_busy_len", blen2, 10);
            end
            sw2++;
            en2   = 0;
            blen2 = 0;
         end
      end
   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic wait_busy(logic v, string n);
      for (int k = 0; k < 200; k++) begin
         if (busy1 === v) return;
         cyc(1);
      end
      miss(n);
   endtask
   task automatic host_write(int a, int v);
      logic rdy;
      b1.wr_valid    = 1'b1;
      b1.wr_addr     = 3'(a);
      b1.wr_activity = 9'(v);
      for (int k = 0; k < 200; k++) begin
         rdy = b1.wr_ready;
         if (busy1) chk("wr_ready_in_sweep", int'(rdy), 0);
         cyc(1);
         if (rdy) begin
            b1.wr_valid = 1'b0;
            return;
         end
      end
      b1.wr_valid = 1'b0;
      miss("host_write_accept");
   endtask
   initial begin
      b1.wr_valid = 1'b0; b1.wr_addr = '0; b1.wr_activity = '0; b1.spike_ready = 1'b1;
      b2.wr_valid = 1'b0; b2.wr_addr = '0; b2.wr_activity = '0; b2.spike_ready = 1'b1;
      cyc(3);
      reset_n = 1'b1;
      rst2_n  = 1'b1;
      chk("reset_busy", int'(busy1), 0);
      chk("reset_wr_ready", int'(b1.wr_ready), 1);
      chk("reset_spike_valid", int'(b1.spike_valid), 0);
      for (int i = 0; i < 8; i++) host_write(i, (i == 3) ? 5 : 0);
      mask = 8'b0100_0010;
      for (int i = 0; i < 8; i++) exp_in.push_back((i == 3) ? st(5, 0) : st(0, 0));
      exp_sp.push_back(1);
      exp_sp.push_back(6);
      sv_cycles = 0;
      en1 = 1'b1;
      wait_busy(1'b1, "sweep1_start");
      wait_busy(1'b0, "sweep1_end");
      cyc(3);
      chk("sweep1_spike_valid_cycles", sv_cycles, 2);
      chk("sweep1_drop_cnt", int'(dc1), 0);
      chk("sweep1_overflow", int'(ovf1), 0);
      chk("sweep1_in_left", exp_in.size(), 0);
      chk("sweep1_sp_left", exp_sp.size(), 0);
      mask = 8'hFF;
      b1.spike_ready = 1'b0;
      for (int i = 0; i < 8; i++) exp_in.push_back((i == 3) ? st(5, 1) : st(0, 1));
      for (int i = 0; i < 4; i++) exp_sp.push_back(i);
      wait_busy(1'b1, "sweep2_start");
      en1 = 1'b0;
      wait_busy(1'b0, "sweep2_end");
      cyc(3);
      chk("ovf_drop_cnt", int'(dc1), 4);
      chk("ovf_overflow", int'(ovf1), 1);
      chk("ovf_spike_valid", int'(b1.spike_valid), 1);
      chk("ovf_head", int'(b1.spike_addr), 0);
      cyc(5);
      chk("ovf_head_held", int'(b1.spike_addr), 0);
      chk("sweep2_in_left", exp_in.size(), 0);
      b1.spike_ready = 1'b1;
      cyc(4);
      chk("drained_spike_valid", int'(b1.spike_valid), 0);
      chk("drained_sp_left", exp_sp.size(), 0);
      chk("overflow_sticky", int'(ovf1), 1);
      mask = 8'h00;
      for (int i = 0; i < 8; i++) exp_in.push_back((i == 3) ? st(5, 2) : st(0, 2));
      en1 = 1'b1;
      wait_busy(1'b1, "sweep3_start");
      chk("sweep3_wr_ready", int'(b1.wr_ready), 0);
      host_write(5, 9);
      chk("write_accepted_idle", int'(busy1), 0);
      chk("sweep3_in_left", exp_in.size(), 0);
      chk("no_tick_miss", int'(tm1), 0);
      for (int i = 0; i < 8; i++) exp_in.push_back((i == 3) ? st(5, 3) : (i == 5) ? st(9, 0) : st(0, 3));
      wait_busy(1'b1, "sweep4_start");
      cyc(4);
      reset_n = 1'b0;
      en1     = 1'b0;
      #1;
      chk("rst_busy", int'(busy1), 0);
      chk("rst_poisson_en", int'(b1.poisson_en), 0);
      chk("rst_poisson_in", int'(b1.poisson_in), 0);
      chk("rst_spike_valid", int'(b1.spike_valid), 0);
      chk("rst_overflow", int'(ovf1), 0);
      chk("rst_tick_miss", int'(tm1), 0);
      chk("rst_drop_cnt", int'(dc1), 0);
      chk("rst_wr_ready", int'(b1.wr_ready), 1);
      exp_in.delete();
      cyc(2);
      reset_n = 1'b1;
      for (int k = 0; k < 200 && sw2 < 3; k++) cyc(1);
      chk("d2_sweeps_seen", int'(sw2 >= 3), 1);
      chk("d2_tick_miss", int'(tm2), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
